pp_accum_sequencer: RTL and testbench

//  Sequential shift-add 8x8 multiply-accumulate controller. It sits directly

---
 rtl/pp_accum_sequencer.sv | 121 ++++++++++++
 tb/tb_pp_accum_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pp_accum_sequencer.sv
// pp_accum_sequencer: sequential shift-add 8x8 multiply-accumulate controller.
// Drives both operands of an external ACC_W-bit ripple adder, registers its sum
// as the accumulator, and hands the accumulated product back over valid/ready.
// Optional build macro: ZERO_SKIP_EN -- leave RUN as soon as no multiplier
// bits remain, so latency follows the msb index of b instead of B_W.
module pp_accum_sequencer #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] add_in1,
  output logic [ACC_W-1:0] add_in2,
  input  logic [ACC_W-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int CNT_W = $clog2(B_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [ACC_W-1:0]   mcand, mcand_next;
  logic [B_W-1:0]     mplier, mplier_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               ovf_reg, ovf_next;
  logic               last_step;

  // Final RUN edge: fixed iteration count, or (with zero skip) no multiplier
  // bits left after this shift.
`ifdef ZERO_SKIP_EN
  assign last_step = ((mplier >> 1) == '0) || (count == CNT_W'(B_W - 1));
`else
  assign last_step = (count == CNT_W'(B_W - 1));
`endif

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      count   <= count_next;
      ovf_reg <= ovf_next;
    end
  end

  // Next-state and datapath updates: accept, one shift-add step per RUN edge, hand-off.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    mcand_next  = mcand;
    mplier_next = mplier;
    count_next  = count;
    ovf_next    = ovf_reg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_next  = ACC_W'(a);
          mplier_next = b;
          count_next  = '0;
          if (acc_clr) begin
            acc_next = '0;
            ovf_next = 1'b0;
          end
`ifdef ZERO_SKIP_EN
          state_next = (b == '0) ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (mplier[0]) begin
          acc_next = add_sum;
          // A sum smaller than the accumulator means the adder wrapped.
          if (add_sum < acc) ovf_next = 1'b1;
        end
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count + CNT_W'(1);
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero multiplier bits present 0 to the adder so it does not toggle.
  assign add_in1   = acc;
  assign add_in2   = (state == RUN && mplier[0]) ? mcand : '0;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pp_accum_sequencer.sv
// Testbench for pp_accum_sequencer: arithmetic reference model of the
// accumulate operation, per-cycle output comparison, directed literal checks
// and randomized operations.
module tb_pp_accum_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        in_ready, out_valid, ovf;
  logic [19:0] add_in1, add_in2, add_sum, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The downstream ripple adder, modelled behaviourally.
  assign add_sum = add_in1 + add_in2;

  pp_accum_sequencer #(.A_W(8), .B_W(8), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_clr(acc_clr), .add_in1(add_in1), .add_in2(add_in2),
    .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 idle, 1 multiplying (step m_step), 2 result held
  int          m_phase = 0;
  int          m_step = 0;
  int          m_nrun = 0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [19:0] m_base = '0, m_acc = '0;
  logic        m_ovf_base = 1'b0, m_ovf = 1'b0;

  // Number of multiply steps an operation takes.
  function automatic int n_run(input logic [7:0] bb);
    int r;
`ifdef ZERO_SKIP_EN
    r = 0;
    for (int i = 0; i < 8; i++) if (bb[i]) r = i + 1;
`else
    r = 8;
`endif
    return r;
  endfunction

  // Exact (unwrapped) base + a * (low k bits of b).
  function automatic logic [31:0] full_sum(input int k);
    logic [31:0] mask;
    mask = (32'd1 << k) - 32'd1;
    return 32'(m_base) + 32'(m_a) * (32'(m_b) & mask);
  endfunction

  function automatic logic [31:0] exp_acc();
    logic [31:0] s;
    if (m_phase == 0) return 32'(m_acc);
    s = full_sum(m_phase == 1 ? m_step : m_nrun);
    return s & 32'hFFFFF;
  endfunction

  function automatic logic exp_ovf();
    logic [31:0] s;
    if (m_phase == 0) return m_ovf;
    s = full_sum(m_phase == 1 ? m_step : m_nrun);
    return m_ovf_base | (s >= 32'h100000);
  endfunction

  function automatic logic [31:0] exp_in2();
    if (m_phase == 1 && m_b[m_step]) return 32'(m_a) << m_step;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_step = 0; m_acc = '0; m_ovf = 1'b0;
      m_base = '0; m_ovf_base = 1'b0; m_a = '0; m_b = '0; m_nrun = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_a = a; m_b = b;
          m_base     = acc_clr ? 20'd0 : m_acc;
          m_ovf_base = acc_clr ? 1'b0 : m_ovf;
          m_nrun = n_run(b);
          m_step = 0;
          m_phase = (m_nrun == 0) ? 2 : 1;
        end
        1: if (m_step + 1 == m_nrun) m_phase = 2; else m_step++;
        default: if (out_ready) begin
          m_acc = 20'(exp_acc());
          m_ovf = exp_ovf();
          m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_in_ready",  32'(in_ready),  32'(m_phase == 0));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("cmp_result",    32'(result),    exp_acc());
      chk("cmp_ovf",       32'(ovf),       32'(exp_ovf()));
      chk("cmp_add_in1",   32'(add_in1),   exp_acc());
      chk("cmp_add_in2",   32'(add_in2),   exp_in2());
    end
  end

  // ---------------- stimulus ----------------
  // One complete operation, starting 2 time units after a rising edge in IDLE.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic clr,
                       input int stall, input logic busy_valid,
                       output logic [19:0] res);
    int lat;
    in_valid = 1'b1; a = ia; b = ib; acc_clr = clr; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = busy_valid; a = 8'($urandom); b = 8'($urandom); acc_clr = 1'($urandom);
    lat = 0;
    while (!out_valid && lat <= 40) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("latency", 32'(lat), 32'(n_run(ib)));
    res = result;
    repeat (stall) begin
      @(posedge clk); #2;
      chk("stall_result", 32'(result), 32'(res));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0; in_valid = 1'b0;
    $display("op a=%02h b=%02h clr=%0d stall=%0d latency=%0d result=%05h ovf=%0d",
             ia, ib, clr, stall, lat, res, ovf);
  endtask

  logic [19:0] r;

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_add_in2", 32'(add_in2), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // 2, 3: basic multiply and accumulate-onto
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, r);
    chk("ffxff", 32'(r), 32'h0FE01);
    chk("ffxff_ovf", 32'(ovf), 32'd0);
    do_op(8'h03, 8'h05, 1'b0, 0, 1'b1, r);
    chk("acc_3x5", 32'(r), 32'h0FE10);

    // 4: sixteen FFxFF then wrap on the seventeenth
    for (int i = 0; i < 16; i++) do_op(8'hFF, 8'hFF, (i == 0), 0, 1'b0, r);
    chk("sum16", 32'(r), 32'hFE010);
    chk("sum16_ovf", 32'(ovf), 32'd0);
    do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, r);
    chk("sum17", 32'(r), 32'h0DE11);
    chk("sum17_ovf", 32'(ovf), 32'd1);
    do_op(8'h01, 8'h01, 1'b1, 0, 1'b0, r);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_result", 32'(r), 32'h00001);

    // 5: held result with in_valid high while stalled
    do_op(8'h12, 8'h34, 1'b0, 5, 1'b1, r);
    chk("stall_value", 32'(r), 32'h003A9);

    // 6: reset mid-run
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; acc_clr = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    do_op(8'h02, 8'h03, 1'b0, 0, 1'b0, r);
    chk("after_rst", 32'(r), 32'h00006);

`ifdef ZERO_SKIP_EN
    // 7: zero-skip latencies (latency checked inside do_op)
    do_op(8'h55, 8'h00, 1'b1, 0, 1'b0, r);
    chk("zs_b0", 32'(r), 32'h00000);
    do_op(8'h55, 8'h01, 1'b0, 0, 1'b0, r);
    chk("zs_b1", 32'(r), 32'h00055);
    do_op(8'h02, 8'h80, 1'b0, 0, 1'b0, r);
    chk("zs_b80", 32'(r), 32'h00155);
`endif

    // Randomized operations, including zero operands and heavy accumulation.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 8'h00;
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      do_op(ra, rb, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
            1'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
